selftrig_fill_sequencer: RTL and testbench
==========================================

Name: selftrig_fill_sequencer

Overview:
Per-fill controller for the self-triggered circular-buffer readout channels. It opens a fill on a fill trigger and drives cbuf_rd_en and cbuf_trig_en, which are shared by all channel readout engines. It closes the acquisition window, waits for every channel to drain its trigger FIFO, then negates cbuf_rd_en so each channel emits its checksum and fill header. It reports fill completion, per-fill waveform counts, drain timeouts and overruns to the control/status logic.

Parameters:
NUM_CHAN, 5, number of channel readout engines sequenced in lockstep
WIN_W, 32, width of the acquisition-window length counter
TMO_W, 24, width of the drain/close timeout counter
CLOSE_HOLD, 16, minimum adc_clk cycles cbuf_rd_en stays negated before the fill is declared done

Ports:
adc_clk  in  1  ADC clock; all logic is on this clock
reset_clk_adc  in  1  synchronous, active-high reset
seq_enable  in  1  level; 0 blocks new fills, and an in-progress fill completes normally
fill_trig  in  1  one-cycle pulse requesting a new fill
window_len  in  WIN_W  acquisition window length in adc_clk cycles; 0 is treated as 1
max_waveforms  in  23  trigger limit per fill; 0 means no limit
drain_timeout  in  TMO_W  cycles allowed in DRAIN or CLOSE before forcing progress
trig_addr_rd_en  in  NUM_CHAN  per-channel trigger-FIFO pops, used to count waveforms
trig_fifo_empty  in  NUM_CHAN  per-channel trigger FIFO empty flags
cbuf_rd_trig_wait  in  NUM_CHAN  per-channel "idle, waiting for trigger or rd_en negation"
cbuf_rd_en  out  1  read enable to all channels
cbuf_trig_en  out  1  trigger enable to all channels
fill_busy  out  1  high in every state except IDLE
fill_done  out  1  one-cycle pulse when a fill closes
fill_waveforms  out  23  waveforms popped on channel 0 in the last completed fill
fill_timeout  out  1  sticky; set when a drain/close timeout fires
fill_overrun_cnt  out  16  number of fill_trig pulses dropped while busy; saturating

Behaviour:
- Reset: state IDLE; all outputs 0; all counters 0. A reset mid-fill drops cbuf_rd_en and cbuf_trig_en on the next edge.
- States: IDLE, ARM, ACQ, DRAIN, CLOSE, DONE. The encoding is a shared enum.
- IDLE
  - fill_trig && seq_enable -> ARM.
  - The window counter loads max(window_len,1).
  - The waveform counter clears.
- ARM (exactly 1 cycle)
  - cbuf_rd_en=1 and cbuf_trig_en=0, so rd_en always leads trig_en by one cycle.
  - Next state is ACQ.
- ACQ
  - cbuf_rd_en=1, cbuf_trig_en=1.
  - The window counter decrements each cycle.
  - Exit to DRAIN on the cycle after the counter reaches 1, or when the waveform count equals a nonzero max_waveforms, whichever comes first.
  - cbuf_trig_en is 0 from the DRAIN-entry cycle onward.
- Waveform count: increments on trig_addr_rd_en[0] in ARM, ACQ and DRAIN. It saturates at 2^23-1.
- DRAIN
  - cbuf_rd_en=1, cbuf_trig_en=0.
  - The timeout counter loads drain_timeout on entry.
  - Go to CLOSE when &trig_fifo_empty && &cbuf_rd_trig_wait has held for 2 consecutive cycles. The 2-cycle filter covers FWFT and subtractor latency in the channels.
  - On timeout reaching 0: set fill_timeout and go to CLOSE.
- CLOSE
  - cbuf_rd_en=0, cbuf_trig_en=0. This is the negation that starts checksum and fill-header emission in the channels.
  - A hold counter runs for CLOSE_HOLD cycles.
  - Exit to DONE after the hold expires AND &cbuf_rd_trig_wait is true.
  - The timeout is reloaded on entry. On expiry: set fill_timeout and go to DONE.
- DONE (1 cycle)
  - fill_done=1.
  - fill_waveforms is latched from the waveform count.
  - Next state is IDLE, so back-to-back fills are separated by at least 1 IDLE cycle.
- fill_trig while fill_busy, or while seq_enable=0 in IDLE: the pulse is dropped and fill_overrun_cnt increments, saturating at 0xFFFF. fill_trig and DONE in the same cycle counts as an overrun.
- seq_enable negated during ARM, ACQ, DRAIN or CLOSE: no effect on the current fill.
- fill_timeout and fill_overrun_cnt clear only on reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package holds:
  - state enum
  - DRAIN_QUAL_CYCLES=2
  - default values of CLOSE_HOLD and the widths
- One sub-module, seq_loadable_downcounter (load, en, value, at_one, at_zero).
  - Instantiated for the window counter, the timeout counter and the hold counter, with width as a parameter.

Test Plan:
1. window_len=100, max_waveforms=0, no triggers, all channels idle and empty -> ACQ lasts 100 cycles; cbuf_trig_en rises 1 cycle after cbuf_rd_en; cbuf_rd_en is low ≥16 cycles; fill_done pulses once; fill_waveforms=0.
2. max_waveforms=3, window_len=10000, trig_addr_rd_en[0] pulses at cycles 5, 20, 40 -> DRAIN entered at cycle 41; fill_waveforms=3.
3. Channel 2 trig_fifo_empty stays 0 for 50 cycles after ACQ ends -> cbuf_rd_en stays 1 until 2 cycles after empty; fill_timeout stays 0.
4. drain_timeout=20, channel 1 cbuf_rd_trig_wait stuck at 0 -> CLOSE entered 20 cycles into DRAIN; fill_timeout=1; DONE reached after a further 20 cycles.
5. fill_trig pulsed 3 times during ACQ, then once with seq_enable=0 in IDLE -> fill_overrun_cnt=4; no extra fills.
6. reset_clk_adc asserted for 1 cycle during ACQ -> next edge: cbuf_rd_en=0, cbuf_trig_en=0, fill_busy=0, fill_overrun_cnt=0.

Source files
------------

// File: rtl/selftrig_fill_sequencer_pkg.sv
// Shared definitions for the self-triggered fill sequencer: state encoding,
// default widths and the drain qualification length.
package selftrig_fill_sequencer_pkg;

  localparam int unsigned NUM_CHAN_DEF   = 5;
  localparam int unsigned WIN_W_DEF      = 32;
  localparam int unsigned TMO_W_DEF      = 24;
  localparam int unsigned CLOSE_HOLD_DEF = 16;

  // Width of the per-fill waveform counter and of the overrun counter.
  localparam int unsigned WF_W  = 23;
  localparam int unsigned OVR_W = 16;

  // Consecutive quiet cycles required before the drain is considered complete.
  localparam int unsigned DRAIN_QUAL_CYCLES = 2;
  localparam int unsigned QUAL_W            = 2;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] seq_state_t;

  localparam seq_state_t StIdle  = 3'd0;
  localparam seq_state_t StArm   = 3'd1;
  localparam seq_state_t StAcq   = 3'd2;
  localparam seq_state_t StDrain = 3'd3;
  localparam seq_state_t StClose = 3'd4;
  localparam seq_state_t StDone  = 3'd5;

endpackage

// File: rtl/seq_loadable_downcounter.sv
// Loadable down-counter that stops at zero. Load wins over decrement.
module seq_loadable_downcounter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             at_one,
  output logic             at_zero
);

  logic [WIDTH-1:0] cnt;

  // Count state: load, else decrement while enabled and nonzero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign value   = cnt;
  assign at_one  = (cnt == WIDTH'(1));
  assign at_zero = (cnt == '0);

endmodule

// File: rtl/selftrig_fill_sequencer.sv
// Per-fill controller for the self-triggered circular-buffer readout channels.
// Opens a fill on fill_trig, runs the acquisition window, waits for every
// channel to drain, then negates cbuf_rd_en so channels emit checksum/header.
module selftrig_fill_sequencer
  import selftrig_fill_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CHAN   = NUM_CHAN_DEF,
  parameter int unsigned WIN_W      = WIN_W_DEF,
  parameter int unsigned TMO_W      = TMO_W_DEF,
  parameter int unsigned CLOSE_HOLD = CLOSE_HOLD_DEF
) (
  input  logic                adc_clk,
  input  logic                reset_clk_adc,
  input  logic                seq_enable,
  input  logic                fill_trig,
  input  logic [WIN_W-1:0]    window_len,
  input  logic [WF_W-1:0]     max_waveforms,
  input  logic [TMO_W-1:0]    drain_timeout,
  input  logic [NUM_CHAN-1:0] trig_addr_rd_en,
  input  logic [NUM_CHAN-1:0] trig_fifo_empty,
  input  logic [NUM_CHAN-1:0] cbuf_rd_trig_wait,
  output logic                cbuf_rd_en,
  output logic                cbuf_trig_en,
  output logic                fill_busy,
  output logic                fill_done,
  output logic [WF_W-1:0]     fill_waveforms,
  output logic                fill_timeout,
  output logic [OVR_W-1:0]    fill_overrun_cnt
);

  localparam int unsigned HOLD_W = $clog2(CLOSE_HOLD + 1);

  seq_state_t        state_q, state_d;
  logic [WF_W-1:0]   wave_q, wave_d;
  logic [QUAL_W-1:0] qual_q, qual_d;
  logic              timeout_set;

  logic              win_load, win_at_one, win_at_zero;
  logic [WIN_W-1:0]  win_load_value, win_value;
  logic              tmo_load, tmo_en, tmo_at_one, tmo_at_zero;
  logic [TMO_W-1:0]  tmo_value;
  logic              hold_load, hold_at_one, hold_at_zero;
  logic [HOLD_W-1:0] hold_value;

  logic all_quiet, all_wait, wave_count_en, wf_limit_hit, tmo_expired, hold_expired;
  logic overrun_hit;
  logic unused_cnt_bits;

  assign all_wait      = &cbuf_rd_trig_wait;
  assign all_quiet     = (&trig_fifo_empty) && all_wait;
  assign tmo_expired   = tmo_at_one || tmo_at_zero;
  assign hold_expired  = hold_at_one || hold_at_zero;
  assign wave_count_en = trig_addr_rd_en[0] &&
                         ((state_q == StArm) || (state_q == StAcq) || (state_q == StDrain));
  // Compare against the count including this cycle's pop so ACQ ends right after the limit pop.
  assign wf_limit_hit  = (max_waveforms != '0) && (wave_d >= max_waveforms);
  assign overrun_hit   = fill_trig && ((state_q != StIdle) || !seq_enable);

  assign win_load       = (state_q == StIdle);
  assign win_load_value = (window_len == '0) ? WIN_W'(1) : window_len;
  assign tmo_load       = (state_d != state_q) && ((state_d == StDrain) || (state_d == StClose));
  assign tmo_en         = (state_q == StDrain) || (state_q == StClose);
  assign hold_load      = (state_q != StClose) && (state_d == StClose);

  assign unused_cnt_bits = ^{win_value, win_at_zero, tmo_value, hold_value,
                             trig_addr_rd_en[NUM_CHAN-1:1]};

  seq_loadable_downcounter #(
    .WIDTH(WIN_W)
  ) u_win_cnt (
    .clk       (adc_clk),
    .reset     (reset_clk_adc),
    .load      (win_load),
    .en        (state_q == StAcq),
    .load_value(win_load_value),
    .value     (win_value),
    .at_one    (win_at_one),
    .at_zero   (win_at_zero)
  );

  seq_loadable_downcounter #(
    .WIDTH(TMO_W)
  ) u_tmo_cnt (
    .clk       (adc_clk),
    .reset     (reset_clk_adc),
    .load      (tmo_load),
    .en        (tmo_en),
    .load_value(drain_timeout),
    .value     (tmo_value),
    .at_one    (tmo_at_one),
    .at_zero   (tmo_at_zero)
  );

  seq_loadable_downcounter #(
    .WIDTH(HOLD_W)
  ) u_hold_cnt (
    .clk       (adc_clk),
    .reset     (reset_clk_adc),
    .load      (hold_load),
    .en        (state_q == StClose),
    .load_value(HOLD_W'(CLOSE_HOLD)),
    .value     (hold_value),
    .at_one    (hold_at_one),
    .at_zero   (hold_at_zero)
  );

  // Next-state logic for the fill FSM.
  always_comb begin
    state_d     = state_q;
    timeout_set = 1'b0;
    case (state_q)
      StIdle:  if (fill_trig && seq_enable) state_d = StArm;
      StArm:   state_d = StAcq;
      StAcq:   if (win_at_one || wf_limit_hit) state_d = StDrain;
      StDrain: begin
        if (all_quiet && (qual_q == QUAL_W'(DRAIN_QUAL_CYCLES - 1))) begin
          state_d = StClose;
        end else if (tmo_expired) begin
          timeout_set = 1'b1;
          state_d     = StClose;
        end
      end
      StClose: begin
        if (hold_expired && all_wait) begin
          state_d = StDone;
        end else if (tmo_expired) begin
          timeout_set = 1'b1;
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Waveform count and drain quiet-cycle filter next values.
  always_comb begin
    wave_d = wave_q;
    if (state_q == StIdle) begin
      wave_d = '0;
    end else if (wave_count_en && (wave_q != '1)) begin
      wave_d = wave_q + 1'b1;
    end
    qual_d = '0;
    if ((state_q == StDrain) && all_quiet && (qual_q != '1)) begin
      qual_d = qual_q + 1'b1;
    end
  end

  // State, counters and registered outputs (decoded from the next state).
  always_ff @(posedge adc_clk) begin
    if (reset_clk_adc) begin
      state_q          <= StIdle;
      wave_q           <= '0;
      qual_q           <= '0;
      cbuf_rd_en       <= 1'b0;
      cbuf_trig_en     <= 1'b0;
      fill_busy        <= 1'b0;
      fill_done        <= 1'b0;
      fill_waveforms   <= '0;
      fill_timeout     <= 1'b0;
      fill_overrun_cnt <= '0;
    end else begin
      state_q      <= state_d;
      wave_q       <= wave_d;
      qual_q       <= qual_d;
      cbuf_rd_en   <= (state_d == StArm) || (state_d == StAcq) || (state_d == StDrain);
      cbuf_trig_en <= (state_d == StAcq);
      fill_busy    <= (state_d != StIdle);
      fill_done    <= (state_d == StDone);
      // Nothing is counted in CLOSE, so wave_q already holds the final count.
      if (state_d == StDone) fill_waveforms <= wave_q;
      if (timeout_set) fill_timeout <= 1'b1;
      if (overrun_hit && (fill_overrun_cnt != '1)) begin
        fill_overrun_cnt <= fill_overrun_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_selftrig_fill_sequencer.sv
// Randomized scoreboard bench for selftrig_fill_sequencer.
module tb_selftrig_fill_sequencer;

  localparam int NC = 5;
  localparam int CH = 16;

  logic          adc_clk = 1'b0;
  logic          reset_clk_adc = 1'b1;
  logic          seq_enable = 1'b0;
  logic          fill_trig = 1'b0;
  logic [31:0]   window_len = '0;
  logic [22:0]   max_waveforms = '0;
  logic [23:0]   drain_timeout = '0;
  logic [NC-1:0] trig_addr_rd_en = '0;
  logic [NC-1:0] trig_fifo_empty = '1;
  logic [NC-1:0] cbuf_rd_trig_wait = '1;
  logic          cbuf_rd_en, cbuf_trig_en, fill_busy, fill_done, fill_timeout;
  logic [22:0]   fill_waveforms;
  logic [15:0]   fill_overrun_cnt;

  selftrig_fill_sequencer dut (
    .adc_clk          (adc_clk),
    .reset_clk_adc    (reset_clk_adc),
    .seq_enable       (seq_enable),
    .fill_trig        (fill_trig),
    .window_len       (window_len),
    .max_waveforms    (max_waveforms),
    .drain_timeout    (drain_timeout),
    .trig_addr_rd_en  (trig_addr_rd_en),
    .trig_fifo_empty  (trig_fifo_empty),
    .cbuf_rd_trig_wait(cbuf_rd_trig_wait),
    .cbuf_rd_en       (cbuf_rd_en),
    .cbuf_trig_en     (cbuf_trig_en),
    .fill_busy        (fill_busy),
    .fill_done        (fill_done),
    .fill_waveforms   (fill_waveforms),
    .fill_timeout     (fill_timeout),
    .fill_overrun_cnt (fill_overrun_cnt)
  );

  always #5 adc_clk = ~adc_clk;

  typedef struct {
    int acq;
    int drn;
    int cls;
    int wf;
    bit tmo;
  } fill_exp_t;

  fill_exp_t exp_q[$];
  fill_exp_t mon_e;
  int  dir_pops[$];
  int  dir_trigs[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  exp_ovr = 0;
  bit  exp_tmo = 1'b0;
  int  fills_exp = 0;
  int  fills_seen = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge adc_clk);
    #1;
  endtask

  // Monitor: measures each fill's phases from the outputs and checks against the scoreboard.
  int arm_n = 0, acq_n = 0, drn_n = 0, cls_n = 0;
  bit seen_trig = 1'b0, after_done = 1'b0;

  always @(negedge adc_clk) begin
    if (reset_clk_adc) begin
      arm_n = 0; acq_n = 0; drn_n = 0; cls_n = 0; seen_trig = 1'b0; after_done = 1'b0;
    end else begin
      if (after_done) begin
        check("done_one_cycle", fill_done, 0);
        check("idle_after_done", fill_busy, 0);
        after_done = 1'b0;
      end
      if (!fill_busy) begin
        arm_n = 0; acq_n = 0; drn_n = 0; cls_n = 0; seen_trig = 1'b0;
      end else if (fill_done) begin
        fills_seen++;
        check("fill_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("arm_cycles", arm_n, 1);
          check("acq_cycles", acq_n, mon_e.acq);
          check("drain_cycles", drn_n, mon_e.drn);
          check("close_cycles", cls_n, mon_e.cls);
          check("fill_waveforms", fill_waveforms, mon_e.wf);
          check("fill_timeout", fill_timeout, mon_e.tmo);
        end
        arm_n = 0; acq_n = 0; drn_n = 0; cls_n = 0; seen_trig = 1'b0;
        after_done = 1'b1;
      end else if (cbuf_trig_en) begin
        acq_n++;
        seen_trig = 1'b1;
      end else if (cbuf_rd_en) begin
        if (seen_trig) drn_n++;
        else arm_n++;
      end else begin
        cls_n++;
      end
    end
  end

  // Reference model plus stimulus for one fill; the trigger is issued at index 0.
  task automatic run_fill(input int wl, input int maxw, input int dt, input int dblk,
                          input int cblk, input int blk_ch, input bit blk_empty,
                          input bit rnd, input bit dis_trig);
    int w, tq, a, d, cl, cl_norm, wf, e_idx, cnt, np, ds, cs, ch;
    bit to, use_empty, tr;
    bit pop[];
    logic [NC-1:0] ev, wv;
    fill_exp_t ex;
    w  = (wl == 0) ? 1 : wl;
    tq = (dt == 0) ? 1 : dt;
    to = 1'b0;
    if (dblk + 2 <= tq) d = dblk + 2;
    else begin d = tq; to = 1'b1; end
    cl_norm = (cblk + 1 > CH) ? cblk + 1 : CH;
    if (cl_norm <= tq) cl = cl_norm;
    else begin cl = tq; to = 1'b1; end
    np  = w + d + cl + 8;
    pop = new[np];
    foreach (pop[i]) pop[i] = rnd ? ($urandom_range(0, 5) == 0) : 1'b0;
    foreach (dir_pops[i]) pop[dir_pops[i]] = 1'b1;
    // Window length, or the first ACQ cycle at which pops since ARM reach the limit.
    a = w;
    cnt = pop[1];
    for (int k = 1; k <= w; k++) begin
      cnt += pop[k+1];
      if (maxw != 0 && cnt >= maxw) begin
        a = k;
        break;
      end
    end
    wf = 0;
    for (int i = 1; i <= a + d + 1; i++) wf += pop[i];
    e_idx = a + d + cl + 2;
    ds = a + 2;
    cs = a + d + 2;
    exp_tmo = exp_tmo | to;
    ex.acq = a; ex.drn = d; ex.cls = cl; ex.wf = wf; ex.tmo = exp_tmo;
    exp_q.push_back(ex);
    fills_exp++;

    window_len    = wl;
    max_waveforms = 23'(maxw);
    drain_timeout = 24'(dt);
    for (int idx = 0; idx <= e_idx; idx++) begin
      tr = (idx == 0);
      if (idx > 0) begin
        foreach (dir_trigs[j]) if (dir_trigs[j] == idx) tr = 1'b1;
        if (rnd && $urandom_range(0, 39) == 0) tr = 1'b1;
        if (tr && exp_ovr < 65535) exp_ovr++;
      end
      fill_trig  = tr;
      seq_enable = (idx == 0 || !rnd) ? 1'b1 : ($urandom_range(0, 3) != 0);
      trig_addr_rd_en = {4'($urandom_range(0, 15)), pop[idx]};
      ch = rnd ? $urandom_range(0, NC - 1) : blk_ch;
      use_empty = rnd ? 1'($urandom_range(0, 1)) : blk_empty;
      ev = rnd ? NC'($urandom_range(0, 31)) : '1;
      wv = rnd ? NC'($urandom_range(0, 31)) : '1;
      if (idx >= ds && idx < cs) begin
        if (idx - ds < dblk) begin
          if (use_empty) ev[ch] = 1'b0;
          else wv[ch] = 1'b0;
        end else begin
          ev = '1;
          wv = '1;
        end
      end else if (idx >= cs && idx < e_idx) begin
        if (idx - cs < cblk) wv[ch] = 1'b0;
        else wv = '1;
      end
      trig_fifo_empty   = ev;
      cbuf_rd_trig_wait = wv;
      cyc();
    end
    fill_trig = 1'b0;
    seq_enable = 1'b1;
    trig_addr_rd_en = '0;
    trig_fifo_empty = '1;
    cbuf_rd_trig_wait = '1;
    if (dis_trig) begin
      fill_trig = 1'b1;
      seq_enable = 1'b0;
      if (exp_ovr < 65535) exp_ovr++;
      cyc();
      fill_trig = 1'b0;
      seq_enable = 1'b1;
    end
    cyc();
    check("overrun_cnt", fill_overrun_cnt, exp_ovr);
    dir_pops.delete();
    dir_trigs.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rd_en"}, cbuf_rd_en, 0);
    check({tag, "_trig_en"}, cbuf_trig_en, 0);
    check({tag, "_busy"}, fill_busy, 0);
    check({tag, "_done"}, fill_done, 0);
    check({tag, "_waveforms"}, fill_waveforms, 0);
    check({tag, "_timeout"}, fill_timeout, 0);
    check({tag, "_overrun"}, fill_overrun_cnt, 0);
  endtask

  initial begin
    repeat (3) cyc();
    check_reset_state("reset");
    reset_clk_adc = 1'b0;
    seq_enable = 1'b1;
    cyc();

    // Plain window, no pops, channels idle.
    run_fill(100, 0, 1000, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    // Waveform limit of 3 ends ACQ right after the third pop.
    dir_pops = '{5, 20, 40};
    run_fill(10000, 3, 1000, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    // Channel 2 FIFO non-empty for 50 drain cycles.
    run_fill(20, 0, 1000, 50, 0, 2, 1'b1, 1'b0, 1'b0);
    // Channel 1 never waits: both drain and close time out.
    run_fill(20, 0, 20, 1000, 1000, 1, 1'b0, 1'b0, 1'b0);
    // Three busy triggers plus one disabled idle trigger.
    dir_trigs = '{10, 20, 30};
    run_fill(40, 0, 1000, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    check("overrun_after_dir", fill_overrun_cnt, 4);

    repeat (25) begin
      run_fill($urandom_range(0, 40),
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0,
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : $urandom_range(40, 80),
               $urandom_range(0, 30), $urandom_range(0, 25), 0, 1'b0, 1'b1,
               1'($urandom_range(0, 1)));
    end

    // Reset in the middle of ACQ.
    window_len = 50;
    max_waveforms = '0;
    drain_timeout = 24'd1000;
    fill_trig = 1'b1;
    cyc();
    fill_trig = 1'b0;
    repeat (3) cyc();
    fill_trig = 1'b1;
    cyc();
    fill_trig = 1'b0;
    if (exp_ovr < 65535) exp_ovr++;
    repeat (3) cyc();
    check("pre_reset_trig_en", cbuf_trig_en, 1);
    check("pre_reset_overrun", fill_overrun_cnt, exp_ovr);
    reset_clk_adc = 1'b1;
    cyc();
    check_reset_state("midfill_reset");
    reset_clk_adc = 1'b0;
    exp_ovr = 0;
    exp_tmo = 1'b0;
    repeat (2) cyc();

    repeat (6) begin
      run_fill($urandom_range(0, 30), 0, $urandom_range(30, 60),
               $urandom_range(0, 20), $urandom_range(0, 20), 0, 1'b0, 1'b1,
               1'($urandom_range(0, 1)));
    end

    repeat (5) cyc();
    check("scoreboard_empty", exp_q.size(), 0);
    check("fill_count", fills_seen, fills_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
